csa_resolver: RTL
=================

CSA_RESOLVER -- requirements
Module: csa_resolver

Purpose: sequential carry-propagate stage that takes the redundant (C, D) pair from the 4-2 compressor tree and returns the binary product bits, CHUNK bits per cycle.

Interface
REQ-001 The block SHALL have parameter LENGTH, default 32, which is the operand width; the datapath width is W = 2*LENGTH.
REQ-002 The block SHALL have parameter CHUNK, default 16, which is the number of bits resolved per cycle; W SHALL be an integer multiple of CHUNK, and N = W/CHUNK.
REQ-003 sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 sys_rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  C_in/D_in hold a valid pair.
REQ-006 in_ready  output  1  block can accept a pair.
REQ-007 C_in  input  W  high-weight vector; bit i has weight 2^(i+1).
REQ-008 D_in  input  W  low-weight vector; bit i has weight 2^i.
REQ-009 out_valid  output  1  result and out_carry are valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 result  output  W  (D_in + (C_in << 1)) mod 2^W.
REQ-012 out_carry  output  1  carry out of bit W-1 of the final chunk add.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE with in_valid=1: on the clock edge, latch D_in and {C_in[W-2:0],1'b0}, clear the chunk index and the carry register, and go to BUSY.
REQ-016 C_in[W-1] SHALL be discarded and SHALL NOT affect result or out_carry.
REQ-017 BUSY, each cycle at index k: {cy, s} = D[k-th chunk] + Cs[k-th chunk] + carry_reg; s is written to result chunk k, cy to carry_reg, and k increments.
REQ-018 After chunk k = N-1 is written, the block SHALL go to DONE with out_carry = final cy; BUSY lasts exactly N cycles.
REQ-019 Latency: if the pair is accepted at edge t, out_valid SHALL first be high in the cycle after edge t+N.
REQ-020 DONE SHALL hold result, out_carry and out_valid stable until out_ready=1; on that edge the block goes to IDLE.
REQ-021 The DONE-to-IDLE edge SHALL NOT accept a new pair, because in_ready is 0 in DONE; back-to-back throughput is one pair per N+2 cycles.
REQ-022 in_valid, C_in and D_in SHALL be ignored outside IDLE; the latched operands SHALL NOT change during BUSY or DONE.
REQ-023 In BUSY, result chunks not yet computed are don't-care; consumers SHALL sample result only when out_valid=1.
REQ-024 out_ready SHALL be ignored outside DONE.

Reset
REQ-025 sys_rst=1 SHALL force, on the next edge, state=IDLE, result=0, out_carry=0, carry_reg=0 and index=0, giving in_ready=1 and out_valid=0.
REQ-026 Reset SHALL take priority over every other transition, including in_valid in IDLE and out_ready in DONE.
REQ-027 Reset in BUSY or DONE SHALL abort the operation with no out_valid pulse, and SHALL leave no residual state in the next accepted operation.

Verification (LENGTH=4, CHUNK=4, so W=8 and N=2)
REQ-028 Basic add: D_in=0x0F, C_in=0x01 accepted at edge t -> out_valid high after edge t+2, result=0x11, out_carry=0.
REQ-029 Wrap-around: D_in=0xFF, C_in=0x01 -> result=0x01, out_carry=1.
REQ-030 Discarded MSB: D_in=0x00, C_in=0x80 -> result=0x00, out_carry=0.
REQ-031 Backpressure: out_ready=0 for 3 cycles in DONE with in_valid=1 throughout -> result stable, in_ready=0, nothing new accepted; then out_ready=1 -> IDLE next cycle and in_ready=1.
REQ-032 Reset mid-BUSY: after accepting 0xFF/0x01, assert sys_rst for 1 cycle in BUSY -> next cycle IDLE, result=0, out_carry=0, out_valid never asserted; a following pair 0x0F/0x01 -> result=0x11.
REQ-033 Back-to-back: hold in_valid=1 and out_ready=1 continuously -> accepts exactly 4 cycles apart (N+2), each result correct.

Source files
------------

// File: rtl/csa_resolver.sv
// -----------------------------------------------------------------------------
// csa_resolver
//
// Sequential carry-propagate stage behind the 4-2 compressor tree. It takes
// the redundant pair (C, D) and resolves it into a binary sum, CHUNK bits per
// clock cycle. The sum is result = (D_in + (C_in << 1)) mod 2^W, where
// W = 2*LENGTH, and out_carry is the carry out of the top bit.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and data stable until that edge. Ready
// never depends on valid: in_ready is 1 only in IDLE, and out_valid is 1
// only in DONE. DONE holds result/out_carry stable until out_ready is seen.
//
// Ports
//   sys_clk    : clock, rising edge
//   sys_rst    : synchronous active-high reset
//   in_valid   : C_in/D_in hold a valid pair
//   in_ready   : block can accept a pair (IDLE only)
//   C_in       : high-weight vector, bit i has weight 2^(i+1)
//   D_in       : low-weight vector, bit i has weight 2^i
//   out_valid  : result/out_carry valid (DONE only)
//   out_ready  : downstream accepts the result
//   result     : resolved sum, W bits
//   out_carry  : carry out of bit W-1 of the final chunk add
//   dbg_state  : current FSM state, for observation only
// -----------------------------------------------------------------------------
module csa_resolver #(
    parameter int LENGTH = 32,
    parameter int CHUNK  = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*LENGTH-1:0]   C_in,
    input  logic [2*LENGTH-1:0]   D_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*LENGTH-1:0]   result,
    output logic                  out_carry,
    output logic [1:0]            dbg_state
);

    localparam int W     = 2 * LENGTH;
    localparam int N     = W / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [W-1:0]     d_reg;
    logic [W-1:0]     c_reg;       // already shifted: bit i has weight 2^i
    logic [IDX_W-1:0] idx;
    logic             carry_reg;

    logic             load;
    logic             step;
    logic             last;
    logic [31:0]      base;
    logic [CHUNK:0]   chunk_sum;

    assign dbg_state = state;

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (idx == LAST_IDX) begin
                    last       = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // One chunk of the ripple: operands of chunk idx plus the carry from the
    // previous chunk. The extra top bit of chunk_sum is the chunk carry-out.
    always_comb begin
        base      = 32'(idx) * 32'(CHUNK);
        chunk_sum = {1'b0, d_reg[base +: CHUNK]}
                  + {1'b0, c_reg[base +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_reg};
    end

    // Datapath registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            d_reg     <= '0;
            c_reg     <= '0;
            idx       <= '0;
            carry_reg <= 1'b0;
            result    <= '0;
            out_carry <= 1'b0;
        end else if (load) begin
            // C_in[W-1] would land at weight 2^W and is dropped by the shift.
            d_reg     <= D_in;
            c_reg     <= {C_in[W-2:0], 1'b0};
            idx       <= '0;
            carry_reg <= 1'b0;
        end else if (step) begin
            result[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
            carry_reg             <= chunk_sum[CHUNK];
            if (last) begin
                out_carry <= chunk_sum[CHUNK];
                idx       <= '0;
            end else begin
                idx       <= idx + IDX_W'(1);
            end
        end
    end

endmodule
